// File: rtl/rv_isa_pkg.sv
// Shared RISC-V ISA definitions for the instruction encoder and the immediate generator.
// The immediate-bit-position function is the single source of truth for the immediate layout.
package rv_isa_pkg;

  typedef enum logic [1:0] {
    FMT_I   = 2'b00,
    FMT_S   = 2'b01,
    FMT_BAD = 2'b10,
    FMT_SB  = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'b00,
    FIFO_ONE   = 2'b01,
    FIFO_FULL  = 2'b10
  } fifo_state_e;

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam int IMM_NONE = -1;

  // Returns the immediate bit carried at instruction bit bit_idx, or IMM_NONE.
  function automatic int imm_bit_pos(input fmt_e fmt, input int bit_idx);
    int pos;
    pos = IMM_NONE;
    case (fmt)
      FMT_I: begin
        if (bit_idx >= 20 && bit_idx <= 31) pos = bit_idx - 20;
      end
      FMT_S: begin
        if (bit_idx >= 25 && bit_idx <= 31) pos = bit_idx - 20;
        else if (bit_idx >= 7 && bit_idx <= 11) pos = bit_idx - 7;
      end
      FMT_SB: begin
        if (bit_idx == 31) pos = 11;
        else if (bit_idx == 7) pos = 10;
        else if (bit_idx >= 25 && bit_idx <= 30) pos = bit_idx - 21;
        else if (bit_idx >= 8 && bit_idx <= 11) pos = bit_idx - 8;
      end
      default: pos = IMM_NONE;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry output buffer with EMPTY/ONE/FULL state; head entry is a register so the
// visible word is registered and holds steady under backpressure.
module instr_fifo2
  import rv_isa_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic         not_full
);

  fifo_state_e  state_reg, state_next;
  logic [W-1:0] head_reg, head_next;
  logic [W-1:0] tail_reg, tail_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= FIFO_EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    case (state_reg)
      FIFO_EMPTY: begin
        if (push) begin
          head_next  = push_data;
          state_next = FIFO_ONE;
        end
      end
      FIFO_ONE: begin
        // Accept and transfer together replace the head directly, so no bubble appears.
        if (push && pop) begin
          head_next = push_data;
        end else if (push) begin
          tail_next  = push_data;
          state_next = FIFO_FULL;
        end else if (pop) begin
          state_next = FIFO_EMPTY;
        end
      end
      FIFO_FULL: begin
        if (pop) begin
          head_next  = tail_reg;
          state_next = FIFO_ONE;
        end
      end
      default: state_next = FIFO_EMPTY;
    endcase
  end

  assign head_data  = head_reg;
  assign head_valid = (state_reg != FIFO_EMPTY);
  assign not_full   = (state_reg != FIFO_FULL);

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded I/S/SB fields and a 64-bit immediate into a 32-bit RISC-V word, buffers
// it in a 2-entry FIFO and tracks the byte write address for the program loader.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [63:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              err,
  output logic              err_sticky
);

  fmt_e        fmt;
  logic [31:0] imm_i, imm_s, imm_sb;
  logic [31:0] word;
  logic        fault, range_err;
  logic        push, pop, fifo_not_full;
  logic [32:0] head_data;
  logic [ADDR_W-1:0] addr_reg;
  logic        err_sticky_reg;

  assign fmt = fmt_e'(opcode[6:5]);

  // Immediate scatter per format, derived at elaboration from the shared bit map.
  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    localparam int PI = imm_bit_pos(FMT_I, gi);
    localparam int PS = imm_bit_pos(FMT_S, gi);
    localparam int PB = imm_bit_pos(FMT_SB, gi);
    if (PI >= 0) begin : g_i
      assign imm_i[gi] = imm[PI];
    end else begin : g_ni
      assign imm_i[gi] = 1'b0;
    end
    if (PS >= 0) begin : g_s
      assign imm_s[gi] = imm[PS];
    end else begin : g_ns
      assign imm_s[gi] = 1'b0;
    end
    if (PB >= 0) begin : g_b
      assign imm_sb[gi] = imm[PB];
    end else begin : g_nb
      assign imm_sb[gi] = 1'b0;
    end
  end

  // The immediate fits in 12 bits only when bits 63..11 are all copies of the sign.
  assign range_err = !((&imm[63:11]) || !(|imm[63:11]));

  always_comb begin
    word        = 32'h0;
    fault       = range_err;
    word[6:0]   = opcode;
    word[14:12] = funct3;
    word[19:15] = rs1;
    case (fmt)
      FMT_I: begin
        word[11:7] = rd;
        word       = word | imm_i;
      end
      FMT_S: begin
        word[24:20] = rs2;
        word        = word | imm_s;
      end
      FMT_SB: begin
        word[24:20] = rs2;
        word        = word | imm_sb;
      end
      default: begin
        word[24:20] = rs2;
        fault       = 1'b1;
      end
    endcase
  end

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign in_ready = reset_n && fifo_not_full;

  instr_fifo2 #(
    .W(33)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({fault, word}),
    .pop       (pop),
    .head_data (head_data),
    .head_valid(out_valid),
    .not_full  (fifo_not_full)
  );

  assign instr = head_data[31:0];
  assign err   = head_data[32];

  // A load overrides any same-cycle transfer, for both the address and the sticky flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg       <= '0;
      err_sticky_reg <= 1'b0;
    end else if (addr_load) begin
      addr_reg       <= addr_base;
      err_sticky_reg <= 1'b0;
    end else if (pop) begin
      addr_reg <= addr_reg + ADDR_W'(4);
      if (err) err_sticky_reg <= 1'b1;
    end
  end

  assign addr       = addr_reg;
  assign err_sticky = err_sticky_reg;

endmodule
